// File: rtl/ddr_wb_arbiter.sv
// Two-master round-robin arbiter onto one 64-bit pipelined Wishbone DDR port; DDR_WB_ARB_PREEMPT_EN enables burst-limit preemption.
// Latency: 1 cycle from cyc to grant; strobes, write data, acks and read data pass through combinationally.
// Backpressure: owner stalled by s_stall_i, the outstanding cap or a preemption hold; non-owners always stalled.
module ddr_wb_arbiter #(
  parameter int g_ADDR_WIDTH      = 32,
  parameter int g_MAX_OUTSTANDING = 4,
  parameter int g_BURST_LIMIT     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [7:0]              m0_sel_i,
  input  logic [g_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [63:0]             m0_dat_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_stall_o,
  output logic [63:0]             m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [7:0]              m1_sel_i,
  input  logic [g_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [63:0]             m1_dat_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_stall_o,
  output logic [63:0]             m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [7:0]              s_sel_o,
  output logic [g_ADDR_WIDTH-1:0] s_adr_o,
  output logic [63:0]             s_dat_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_stall_i,
  input  logic [63:0]             s_dat_i,
  output logic [1:0]              grant_o
);

  if (g_MAX_OUTSTANDING < 1 || g_MAX_OUTSTANDING > 15 || g_BURST_LIMIT < 1) begin : g_param_check
    $error("ddr_wb_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t     state;
  logic       last_owner;  // 1: m1 owned last, so m0 wins the next tie
  logic [3:0] cnt;
  logic       own0, own1, cap, issue, resp;
  logic       hold0, hold1, handover;

  assign own0  = (state == OWN0);
  assign own1  = (state == OWN1);
  assign cap   = (cnt == 4'(g_MAX_OUTSTANDING));
  assign issue = s_stb_o & ~s_stall_i;
  assign resp  = (s_ack_i | s_err_i) & (cnt != 4'd0);

`ifdef DDR_WB_ARB_PREEMPT_EN
  localparam int BW = $clog2(g_BURST_LIMIT + 1);
  logic [BW-1:0] burst;
  logic          at_limit;

  assign at_limit = (burst >= BW'(g_BURST_LIMIT));
  assign hold0    = own0 & at_limit & m1_cyc_i;
  assign hold1    = own1 & at_limit & m0_cyc_i;
  assign handover = (cnt == 4'd0) & ((hold0 & m0_cyc_i) | (hold1 & m1_cyc_i));

  // Saturates at the limit so a late-arriving peer can preempt at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst <= '0;
    end else if (handover || !(own0 || own1)) begin
      burst <= '0;
    end else if (issue && !at_limit) begin
      burst <= burst + 1'b1;
    end
  end
`else
  assign hold0    = 1'b0;
  assign hold1    = 1'b0;
  assign handover = 1'b0;
`endif

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~cap & ~hold0;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~cap & ~hold1;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      DRAIN:   s_cyc_o = 1'b1;
      default: s_cyc_o = 1'b0;
    endcase
  end

  // Responses after the owner drops cyc are counted but never presented.
  assign m0_ack_o   = own0 & m0_cyc_i & s_ack_i;
  assign m0_err_o   = own0 & m0_cyc_i & s_err_i;
  assign m1_ack_o   = own1 & m1_cyc_i & s_ack_i;
  assign m1_err_o   = own1 & m1_cyc_i & s_err_i;
  assign m0_stall_o = own0 ? (s_stall_i | cap | hold0) : 1'b1;
  assign m1_stall_o = own1 ? (s_stall_i | cap | hold1) : 1'b1;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= 4'd0;
    end else if (issue && !resp) begin
      cnt <= cnt + 4'd1;
    end else if (resp && !issue) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant_o    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
            state      <= OWN0;
            grant_o    <= 2'b01;
            last_owner <= 1'b0;
          end else if (m1_cyc_i) begin
            state      <= OWN1;
            grant_o    <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            state   <= (cnt == 4'd0) ? IDLE : DRAIN;
            grant_o <= 2'b00;
          end else if (handover) begin
            state      <= OWN1;
            grant_o    <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            state   <= (cnt == 4'd0) ? IDLE : DRAIN;
            grant_o <= 2'b00;
          end else if (handover) begin
            state      <= OWN0;
            grant_o    <= 2'b01;
            last_owner <= 1'b0;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wb_arbiter.sv
// Randomized bench for ddr_wb_arbiter: two random masters and a random slave against a cycle-level reference model.
module tb_ddr_wb_arbiter;
  localparam int AW   = 32;
  localparam int MAXO = 4;
  localparam int BL   = 16;
`ifdef DDR_WB_ARB_PREEMPT_EN
  localparam int MAXREM = 40;
`else
  localparam int MAXREM = 20;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [1:0]    cyc, stb, we;
  logic [7:0]    sel  [2];
  logic [AW-1:0] adr  [2];
  logic [63:0]   wdat [2];
  logic [1:0]    ack, err, stall;
  logic [63:0]   rdat [2];
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [7:0]    s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [63:0]   s_dat_o;
  logic          s_ack_i, s_err_i, s_stall_i;
  logic [63:0]   s_dat_i;
  logic [1:0]    grant_o;

  always #5 clk_i = ~clk_i;

  ddr_wb_arbiter #(.g_ADDR_WIDTH(AW), .g_MAX_OUTSTANDING(MAXO), .g_BURST_LIMIT(BL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m0_stall_o(stall[0]), .m0_dat_o(rdat[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .m1_stall_o(stall[1]), .m1_dat_o(rdat[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_stall_i(s_stall_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the port, whether it is draining, and how many requests are in flight.
  int own, last, outs, burst;
  bit drain;
  bit e_cyc, e_stb, e_we, e_active, e_hold;
  logic [7:0]    e_sel;
  logic [AW-1:0] e_adr;
  logic [63:0]   e_dat;
  logic [1:0]    e_grant, e_stall, e_ack, e_err, acc;

  int rem [2];
  int p_req [2];
  int p_ack, p_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; drain = 0; last = 1; outs = 0; burst = 0; acc = '0;
  endtask

  task automatic compute_exp();
    e_active = (own >= 0) && !drain;
    e_hold   = 1'b0;
`ifdef DDR_WB_ARB_PREEMPT_EN
    if (e_active) e_hold = (burst >= BL) && cyc[1-own];
`endif
    e_cyc = drain; e_stb = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
    e_grant = '0; e_stall = 2'b11; e_ack = '0; e_err = '0;
    if (e_active) begin
      e_cyc = cyc[own];
      e_stb = stb[own] && (outs != MAXO) && !e_hold;
      e_we = we[own]; e_sel = sel[own]; e_adr = adr[own]; e_dat = wdat[own];
      e_grant[own] = 1'b1;
      e_stall[own] = s_stall_i || (outs == MAXO) || e_hold;
      e_ack[own]   = cyc[own] && s_ack_i;
      e_err[own]   = cyc[own] && s_err_i;
    end
  endtask

  task automatic model_update();
    bit issue, resp;
    int old;
    issue = e_stb && !s_stall_i;
    resp  = (s_ack_i || s_err_i) && (outs > 0);
    old   = outs;
    acc   = '0;
    if (issue) acc[own] = 1'b1;
    outs = outs + int'(issue) - int'(resp);
    if (e_active) burst += int'(issue);
    if (own < 0) begin
      if (cyc[0] && (!cyc[1] || last == 1)) own = 0;
      else if (cyc[1]) own = 1;
      if (own >= 0) begin last = own; burst = 0; end
    end else if (drain) begin
      if (old == 0) begin own = -1; drain = 0; end
    end else if (!cyc[own]) begin
      if (old == 0) own = -1; else drain = 1;
      burst = 0;
    end else if (e_hold && old == 0) begin
      own = 1 - own; last = own; burst = 0;
    end
  endtask

  task automatic new_fields(input int i);
    we[i]   = $urandom_range(1);
    sel[i]  = 8'($urandom);
    adr[i]  = {$urandom} & ~32'h7;
    wdat[i] = {$urandom, $urandom};
  endtask

  task automatic drive_next();
    s_stall_i = ($urandom_range(99) < p_stall);
    s_ack_i = 0; s_err_i = 0;
    if (outs > 0 && $urandom_range(99) < p_ack) begin
      if ($urandom_range(99) < 10) s_err_i = 1; else s_ack_i = 1;
    end else if (outs == 0 && $urandom_range(99) < 2) begin
      s_ack_i = 1;  // stray ack must be dropped
    end
    s_dat_i = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      if (!cyc[i]) begin
        if ($urandom_range(99) < p_req[i]) begin
          cyc[i] = 1; stb[i] = 1; rem[i] = $urandom_range(MAXREM, 1); new_fields(i);
        end
      end else begin
        if (acc[i]) begin
          rem[i]--; stb[i] = 0;
          if (rem[i] > 0) begin new_fields(i); stb[i] = ($urandom_range(99) < 80); end
        end else if (!stb[i] && rem[i] > 0) begin
          stb[i] = ($urandom_range(99) < 50);
        end
        if (rem[i] == 0 && $urandom_range(99) < 30) cyc[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    compute_exp();
    chk("s_cyc", s_cyc_o, e_cyc);
    chk("s_stb", s_stb_o, e_stb);
    chk("s_we", s_we_o, e_we);
    chk("s_sel", s_sel_o, e_sel);
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_dat);
    chk("grant", grant_o, e_grant);
    chk("stall", stall, e_stall);
    chk("ack", ack, e_ack);
    chk("err", err, e_err);
    chk("m0_dat", rdat[0], s_dat_i);
    chk("m1_dat", rdat[1], s_dat_i);
    @(posedge clk_i);
    model_update();
    #1;
    drive_next();
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; rem[0] = 0; rem[1] = 0;
    for (int i = 0; i < 2; i++) begin sel[i] = '0; adr[i] = '0; wdat[i] = '0; end
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0; s_dat_i = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_cyc"}, s_cyc_o, 1'b0);
    chk({tag, "_s_stb"}, s_stb_o, 1'b0);
    chk({tag, "_s_we"}, s_we_o, 1'b0);
    chk({tag, "_s_sel"}, s_sel_o, 8'h00);
    chk({tag, "_s_adr"}, s_adr_o, '0);
    chk({tag, "_s_dat"}, s_dat_o, '0);
    chk({tag, "_grant"}, grant_o, 2'b00);
    chk({tag, "_stall"}, stall, 2'b11);
    chk({tag, "_ack"}, ack, 2'b00);
    chk({tag, "_err"}, err, 2'b00);
  endtask

  // Both masters request together straight out of reset: m0 must win.
  task automatic tie_test(input string tag);
    cyc = 2'b11; stb = 2'b11; rem[0] = 3; rem[1] = 3;
    new_fields(0); new_fields(1);
    step();
    chk({tag, "_grant"}, grant_o, 2'b01);
  endtask

  task automatic run_phase(input int n, input int r0, input int r1, input int pa, input int ps);
    p_req[0] = r0; p_req[1] = r1; p_ack = pa; p_stall = ps;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    bit found;
    clear_inputs();
    p_req[0] = 0; p_req[1] = 0; p_ack = 0; p_stall = 0;
    model_reset();
    rst_n_i = 1'b1;
    #1 rst_n_i = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tie_test("tie0");
    run_phase(500, 60, 0, 50, 20);
    run_phase(500, 50, 50, 40, 20);
    run_phase(500, 60, 60, 8, 0);
    run_phase(500, 40, 40, 70, 50);

    // Reset in the middle of an m1 burst with requests still in flight.
    found = 0;
    p_req[0] = 0; p_req[1] = 90; p_ack = 10; p_stall = 10;
    for (int c = 0; c < 3000 && !found; c++) begin
      step();
      found = (own == 1) && !drain && (outs >= 3);
    end
    chk("rst_setup", found, 1'b1);
    rst_n_i = 1'b0;
    clear_inputs();
    #1 check_reset("midrst");
    model_reset();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tie_test("tie1");
    run_phase(400, 50, 50, 40, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
